// File: rtl/homography_query_arbiter.sv
// Round-robin arbiter sharing one pipelined homography engine between two requesters.
// Optional MISMATCH_CHECK_EN: store issued coordinates per tag and flag echo mismatches.
module homography_query_arbiter #(
    parameter int unsigned MAX_INFLIGHT = 5,
    parameter int unsigned XW           = 10
) (
    input  logic          clk_25,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [XW-1:0] req0_x,
    input  logic [XW-1:0] req0_y,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [XW-1:0] req1_x,
    input  logic [XW-1:0] req1_y,
    output logic          req1_ready,
    output logic [XW-1:0] query_x,
    output logic [XW-1:0] query_y,
    output logic          start,
    input  logic          ready,
    input  logic [XW-1:0] return_x,
    input  logic [XW-1:0] return_y,
    input  logic [4:0]    r,
    input  logic [5:0]    g,
    input  logic [4:0]    b,
    output logic          rsp0_val,
    output logic          rsp1_val,
    output logic [XW-1:0] rsp_x,
    output logic [XW-1:0] rsp_y,
    output logic [4:0]    rsp_r,
    output logic [5:0]    rsp_g,
    output logic [4:0]    rsp_b,
    output logic          underflow,
    output logic          mismatch
);

    localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_INFLIGHT);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_INFLIGHT - 1);

    logic [CntW-1:0] inflight_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic            rr_q;

    logic            can_issue;
    logic            grant0;
    logic            grant1;
    logic            transfer;
    logic            pop;
    logic            head_id;
    logic [XW-1:0]   grant_x;
    logic [XW-1:0]   grant_y;

    logic            id_mem [MAX_INFLIGHT];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // A return in the same cycle frees a slot, so a full engine can still accept one query.
    assign can_issue = (inflight_q < MaxCnt) || ready;

    // rr_q=1 means requester 1 has priority when both are valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && can_issue) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~rr_q;
                grant1 = rr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign transfer   = grant0 | grant1;
    assign grant_x    = grant1 ? req1_x : req0_x;
    assign grant_y    = grant1 ? req1_y : req0_y;
    assign pop        = ready && (inflight_q != '0);
    assign head_id    = id_mem[rd_ptr_q];

    // Tag storage carries no reset; occupancy is tracked solely by inflight_q.
    always_ff @(posedge clk_25) begin
        if (transfer) begin
            id_mem[wr_ptr_q] <= grant1;
        end
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_q       <= 1'b0;
            start      <= 1'b0;
            query_x    <= '0;
            query_y    <= '0;
            rsp0_val   <= 1'b0;
            rsp1_val   <= 1'b0;
            rsp_x      <= '0;
            rsp_y      <= '0;
            rsp_r      <= '0;
            rsp_g      <= '0;
            rsp_b      <= '0;
            underflow  <= 1'b0;
        end else begin
            if (transfer) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
                rr_q     <= grant0;
                query_x  <= grant_x;
                query_y  <= grant_y;
            end
            start <= transfer;

            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                rsp_x    <= return_x;
                rsp_y    <= return_y;
                rsp_r    <= r;
                rsp_g    <= g;
                rsp_b    <= b;
            end
            rsp0_val <= pop && !head_id;
            rsp1_val <= pop && head_id;

            unique case ({transfer, pop})
                2'b10:   inflight_q <= inflight_q + CntW'(1);
                2'b01:   inflight_q <= inflight_q - CntW'(1);
                default: inflight_q <= inflight_q;
            endcase

            if (ready && (inflight_q == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef MISMATCH_CHECK_EN
    logic [XW-1:0] x_mem [MAX_INFLIGHT];
    logic [XW-1:0] y_mem [MAX_INFLIGHT];

    always_ff @(posedge clk_25) begin
        if (transfer) begin
            x_mem[wr_ptr_q] <= grant_x;
            y_mem[wr_ptr_q] <= grant_y;
        end
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (pop && ((return_x != x_mem[rd_ptr_q]) || (return_y != y_mem[rd_ptr_q]))) begin
            mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule
